// File: rtl/cv32e40p_wb_port_arbiter.sv
// Buffered N-channel write-back arbiter: per-producer FIFOs drained one entry
// per cycle onto a single register-file write port.
module cv32e40p_wb_port_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 6,
  parameter int RR         = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  input  logic [NUM_CH*ADDR_W-1:0] ch_waddr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  input  logic                     flush_i,
  input  logic                     rf_ready_i,
  output logic                     rf_we_o,
  output logic [ADDR_W-1:0]        rf_waddr_o,
  output logic [DATA_W-1:0]        rf_wdata_o,
  output logic                     busy_o,
  output logic                     contention_o,
  input  logic                     clr_cnt_i,
  output logic [CNT_W-1:0]         contention_cnt_o
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [NUM_CH][FIFO_DEPTH];
  logic [FW-1:0]     rd_ptr   [NUM_CH];
  logic [FW-1:0]     wr_ptr   [NUM_CH];
  logic [CW-1:0]     count    [NUM_CH];

  logic [NUM_CH-1:0] req, push, pop;
  logic [PW-1:0]     rr_ptr, gnt_idx;
  logic [PW:0]       nreq;
  logic              gnt_any, grant;

  function automatic logic [FW-1:0] next_ptr(input logic [FW-1:0] p);
    return (p == FW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    nreq = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_ready_o[c] = (count[c] != CW'(FIFO_DEPTH));
      req[c]        = (count[c] != '0);
      push[c]       = ch_valid_i[c] & ch_ready_o[c] & ~flush_i;
      nreq          = nreq + (PW+1)'(req[c]);
    end
  end

  always_comb begin
    int c;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    if (RR != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (int'(rr_ptr) + k) % NUM_CH;
        if (!gnt_any && req[c]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(c);
        end
      end
    end else begin
      // descending scan so the lowest requesting index is the last to land
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
  end

  assign grant        = gnt_any & rf_ready_i & ~flush_i;
  assign rf_we_o      = grant;
  assign rf_waddr_o   = grant ? mem_addr[gnt_idx][rd_ptr[gnt_idx]] : '0;
  assign rf_wdata_o   = grant ? mem_data[gnt_idx][rd_ptr[gnt_idx]] : '0;
  assign busy_o       = |req;
  assign contention_o = grant & (nreq >= (PW+1)'(2));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) pop[c] = grant && (gnt_idx == PW'(c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count[c]  <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
    end else if (flush_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count[c]  <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= next_ptr(wr_ptr[c]);
        if (pop[c])  rd_ptr[c] <= next_ptr(rd_ptr[c]);
        if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
        else if (!push[c] && pop[c]) count[c] <= count[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_addr[c][wr_ptr[c]] <= ch_waddr_i[c*ADDR_W +: ADDR_W];
        mem_data[c][wr_ptr[c]] <= ch_wdata_i[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= PW'(NUM_CH - 1);
      contention_cnt_o <= '0;
    end else begin
      if (grant) rr_ptr <= gnt_idx;
      if (clr_cnt_i)
        contention_cnt_o <= '0;
      else if (contention_o && (contention_cnt_o != '1))
        contention_cnt_o <= contention_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_wb_port_arbiter.sv
// Bench for cv32e40p_wb_port_arbiter: a round-robin depth-2 instance and a
// fixed-priority depth-3 instance with a 3-bit counter share one stimulus.
module tb_cv32e40p_wb_port_arbiter;
  localparam int N = 3;
  typedef logic [37:0] ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    valid;
  logic [N*6-1:0]  waddr;
  logic [N*32-1:0] wdata;
  logic flush, rf_ready, clr;

  logic [N-1:0] rdy_a, rdy_b;
  logic we_a, we_b, busy_a, busy_b, cont_a, cont_b;
  logic [5:0] wa_a, wa_b;
  logic [31:0] wd_a, wd_b;
  logic [15:0] cnt_a;
  logic [2:0] cnt_b;

  cv32e40p_wb_port_arbiter #(.NUM_CH(N), .FIFO_DEPTH(2), .DATA_W(32), .ADDR_W(6), .RR(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_valid_i(valid), .ch_ready_o(rdy_a), .ch_waddr_i(waddr),
    .ch_wdata_i(wdata), .flush_i(flush), .rf_ready_i(rf_ready), .rf_we_o(we_a), .rf_waddr_o(wa_a),
    .rf_wdata_o(wd_a), .busy_o(busy_a), .contention_o(cont_a), .clr_cnt_i(clr), .contention_cnt_o(cnt_a));

  cv32e40p_wb_port_arbiter #(.NUM_CH(N), .FIFO_DEPTH(3), .DATA_W(32), .ADDR_W(6), .RR(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_valid_i(valid), .ch_ready_o(rdy_b), .ch_waddr_i(waddr),
    .ch_wdata_i(wdata), .flush_i(flush), .rf_ready_i(rf_ready), .rf_we_o(we_b), .rf_waddr_o(wa_b),
    .rf_wdata_o(wd_b), .busy_o(busy_b), .contention_o(cont_b), .clr_cnt_i(clr), .contention_cnt_o(cnt_b));

  logic [N-1:0] o_rdy [2];
  logic         o_we [2], o_busy [2], o_cont [2];
  logic [5:0]   o_wa [2];
  logic [31:0]  o_wd [2];
  logic [15:0]  o_cnt [2];
  assign o_rdy[0] = rdy_a;  assign o_rdy[1] = rdy_b;
  assign o_we[0] = we_a;    assign o_we[1] = we_b;
  assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;
  assign o_cont[0] = cont_a; assign o_cont[1] = cont_b;
  assign o_wa[0] = wa_a;    assign o_wa[1] = wa_b;
  assign o_wd[0] = wd_a;    assign o_wd[1] = wd_b;
  assign o_cnt[0] = cnt_a;  assign o_cnt[1] = {13'b0, cnt_b};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one queue per channel per instance, indexed m*N+c
  ent_t  q [2*N][$];
  int    ptr [2];
  int    cnt [2];
  int    depth [2] = '{2, 3};
  int    rrm [2]   = '{1, 0};
  int    cmax [2]  = '{65535, 7};
  string nm [2]    = '{"a", "b"};

  always @(negedge clk) begin
    int nreq, g, c;
    logic [N-1:0] acc, erdy;
    ent_t e;
    logic econt;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < N; k++) q[m*N+k].delete();
        ptr[m] = N - 1;
        cnt[m] = 0;
        chk({nm[m], "_rst_we"}, 64'(o_we[m]), 64'd0);
        chk({nm[m], "_rst_wa"}, 64'(o_wa[m]), 64'd0);
        chk({nm[m], "_rst_wd"}, 64'(o_wd[m]), 64'd0);
        chk({nm[m], "_rst_busy"}, 64'(o_busy[m]), 64'd0);
        chk({nm[m], "_rst_cont"}, 64'(o_cont[m]), 64'd0);
        chk({nm[m], "_rst_rdy"}, 64'(o_rdy[m]), 64'b111);
        chk({nm[m], "_rst_cnt"}, 64'(o_cnt[m]), 64'd0);
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        nreq = 0;
        g = -1;
        for (int k = 0; k < N; k++) if (q[m*N+k].size() > 0) nreq++;
        if (rf_ready && !flush && nreq > 0) begin
          if (rrm[m] != 0) begin
            for (int k = 1; k <= N; k++) begin
              c = (ptr[m] + k) % N;
              if (g < 0 && q[m*N+c].size() > 0) g = c;
            end
          end else begin
            for (int k = 0; k < N; k++) if (g < 0 && q[m*N+k].size() > 0) g = k;
          end
        end
        e = (g >= 0) ? q[m*N+g][0] : '0;
        econt = (g >= 0) && (nreq >= 2);
        for (int k = 0; k < N; k++) erdy[k] = (q[m*N+k].size() != depth[m]);
        chk({nm[m], "_we"}, 64'(o_we[m]), 64'(g >= 0));
        chk({nm[m], "_waddr"}, 64'(o_wa[m]), 64'(e[37:32]));
        chk({nm[m], "_wdata"}, 64'(o_wd[m]), 64'(e[31:0]));
        chk({nm[m], "_busy"}, 64'(o_busy[m]), 64'(nreq > 0));
        chk({nm[m], "_cont"}, 64'(o_cont[m]), 64'(econt));
        chk({nm[m], "_ready"}, 64'(o_rdy[m]), 64'(erdy));
        chk({nm[m], "_cnt"}, 64'(o_cnt[m]), 64'(cnt[m]));
        for (int k = 0; k < N; k++) acc[k] = valid[k] && erdy[k] && !flush;
        if (g >= 0) begin
          void'(q[m*N+g].pop_front());
          ptr[m] = g;
        end
        for (int k = 0; k < N; k++)
          if (acc[k]) q[m*N+k].push_back({waddr[k*6 +: 6], wdata[k*32 +: 32]});
        if (flush) for (int k = 0; k < N; k++) q[m*N+k].delete();
        if (clr) cnt[m] = 0;
        else if (econt && cnt[m] < cmax[m]) cnt[m]++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0;
    flush = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic push(input int c, input logic [5:0] a, input logic [31:0] d);
    valid[c] = 1'b1;
    waddr[c*6 +: 6] = a;
    wdata[c*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    waddr = '0;
    wdata = '0;
    rf_ready = 1'b1;
    cyc();
    #2 chk("rst_ready_lit", 64'(rdy_a), 64'b111);
    do_reset();

    // single write from ch1
    cyc(); idle(); push(1, 6'd5, 32'hDEADBEEF);
    cyc(); idle();
    #2 chk("t1_we", 64'(we_a), 64'd1);
    chk("t1_waddr", 64'(wa_a), 64'd5);
    chk("t1_wdata", 64'(wd_a), 64'hDEADBEEF);
    cyc();
    #2 chk("t1_busy", 64'(busy_a), 64'd0);

    // round-robin from reset: ch0, ch1, ch2
    do_reset();
    cyc(); idle();
    for (int c = 0; c < N; c++) push(c, 6'(c + 1), 32'(32'h100 + c));
    for (int i = 1; i <= 3; i++) begin
      cyc(); idle();
      #2 chk("t2_waddr", 64'(wa_a), 64'(i));
      chk("t2_cont", 64'(cont_a), 64'(i < 3));
    end
    cyc();
    #2 chk("t2_cnt", 64'(cnt_a), 64'd2);

    // fixed priority: ch2 waits for ch0 to drain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(); idle();
      if (i < 5) push(0, 6'(10 + i), 32'(i));
      if (i == 0) push(2, 6'd20, 32'h2020);
      #2;
      if (i >= 1 && i <= 5) chk("t3_ch0", 64'(wa_b), 64'(10 + i - 1));
      if (i == 6) chk("t3_ch2", 64'(wa_b), 64'd20);
      if (i == 7) chk("t3_idle", 64'(we_b), 64'd0);
    end

    // backpressure on a full FIFO
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(); idle();
      rf_ready = (i >= 5);
      if (i == 0) push(1, 6'd11, 32'hAAAA);
      if (i == 1) push(1, 6'd12, 32'hBBBB);
      if (i >= 2 && i <= 6) push(1, 6'd13, 32'hCCCC);
      #2;
      if (i == 2) chk("t4_full", 64'(rdy_a[1]), 64'd0);
      if (i == 5) begin
        chk("t4_A", 64'(wa_a), 64'd11);
        chk("t4_rdy5", 64'(rdy_a[1]), 64'd0);
      end
      if (i == 6) begin
        chk("t4_B", 64'(wa_a), 64'd12);
        chk("t4_rdy6", 64'(rdy_a[1]), 64'd1);
      end
      if (i == 7) chk("t4_C", 64'(wa_a), 64'd13);
    end

    // flush with pending entries and a simultaneous push
    do_reset();
    rf_ready = 1'b0;
    cyc(); idle(); push(0, 6'd30, 32'h30);
    cyc(); idle(); push(1, 6'd31, 32'h31);
    cyc(); idle();
    cyc(); idle(); flush = 1'b1; rf_ready = 1'b1; push(0, 6'd32, 32'h32);
    #2 chk("t5_we", 64'(we_a), 64'd0);
    cyc(); idle();
    #2 chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_rdy", 64'(rdy_a), 64'b111);
    cyc();
    #2 chk("t5_nowrite", 64'(we_a), 64'd0);

    // saturating counter, then async reset mid-drain
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(); idle();
      for (int c = 0; c < N; c++) push(c, 6'(c * 8 + i), 32'(i * 16 + c));
      #2;
      if (i == 11) chk("t6_sat", 64'(cnt_b), 64'd7);
    end
    cyc(); idle();
    #2 rst_n = 1'b0;
    #1 chk("t6_async_we", 64'(we_a), 64'd0);
    chk("t6_async_cnt", 64'(cnt_b), 64'd0);
    chk("t6_async_busy", 64'(busy_a), 64'd0);
    cyc();
    cyc(); rst_n = 1'b1;
    cyc(); idle(); push(2, 6'd42, 32'h42); push(0, 6'd40, 32'h40);
    cyc(); idle(); clr = 1'b1;
    #2 chk("t6_first", 64'(wa_a), 64'd40);
    chk("t6_cont", 64'(cont_a), 64'd1);
    cyc(); idle();
    #2 chk("t6_clr", 64'(cnt_a), 64'd0);
    chk("t6_second", 64'(wa_a), 64'd42);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
